cmos_y_capture: RTL

CMOS_Y_CAPTURE -- requirements
Module: cmos_y_capture

---
 rtl/cmos_y_capture.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/cmos_y_capture.sv
// rtl/cmos_y_capture.sv - DVP YUV422 capture quantizing luma to 2 bits with pixel/line/frame tracking
module cmos_y_capture #(
  parameter int IMG_W       = 640,
  parameter int IMG_H       = 480,
  parameter int SKIP_FRAMES = 2,
  parameter int TH1         = 64,
  parameter int TH2         = 128,
  parameter int TH3         = 192
) (
  input  logic       cmos_pclk,
  input  logic       rst_n,
  input  logic       cmos_vsync,
  input  logic       cmos_href,
  input  logic [7:0] cmos_data,
  output logic [1:0] cam_y,
  output logic       cam_valid,
  output logic [9:0] pix_x,
  output logic [8:0] pix_y,
  output logic       frame_start,
  output logic       frame_end,
  output logic       cap_err
);

  localparam int SKW = (SKIP_FRAMES < 2) ? 1 : $clog2(SKIP_FRAMES + 1);
  localparam logic [SKW-1:0] SKIP_N = SKW'(SKIP_FRAMES);
  localparam logic [10:0]    W_N    = 11'(IMG_W);
  localparam logic [9:0]     H_N    = 10'(IMG_H);

  typedef enum logic [1:0] {ST_SKIP, ST_WAIT, ST_ACTIVE} state_t;
  localparam state_t ST_INIT = (SKIP_FRAMES == 0) ? ST_WAIT : ST_SKIP;

  state_t         state_q, state_d;
  logic           vs1_q, vs1_d, hr1_q, hr1_d, vs2_q, vs2_d, hr2_q, hr2_d;
  logic [7:0]     d1_q, d1_d, y_q, y_d;
  logic [SKW-1:0] skip_q, skip_d;
  logic           phase_q, phase_d;
  logic [10:0]    col_q, col_d;
  logic [9:0]     row_q, row_d;
  logic [1:0]     cam_y_q, cam_y_d;
  logic           cam_valid_q, cam_valid_d;
  logic [9:0]     pix_x_q, pix_x_d;
  logic [8:0]     pix_y_q, pix_y_d;
  logic           fs_q, fs_d, fe_q, fe_d, err_q, err_d;

  logic        vs_rise, vs_fall, hr_rise, hr_fall, cur_phase, pix_done, active;
  logic [9:0]  rows_done;

  // Edges are taken between S1 and its delayed copy, never on raw pins
  assign vs_rise   = vs1_q & ~vs2_q;
  assign vs_fall   = ~vs1_q & vs2_q;
  assign hr_rise   = hr1_q & ~hr2_q;
  assign hr_fall   = ~hr1_q & hr2_q;
  assign cur_phase = hr_rise ? 1'b0 : phase_q;
  assign pix_done  = hr1_q & cur_phase;
  assign active    = (state_q == ST_ACTIVE);
  assign rows_done = row_q + 10'(hr_fall);

  function automatic logic [1:0] quant(input logic [7:0] y);
    if (y < 8'(TH1)) return 2'd0;
    if (y < 8'(TH2)) return 2'd1;
    if (y < 8'(TH3)) return 2'd2;
    return 2'd3;
  endfunction

  always_comb begin
    vs1_d       = cmos_vsync;
    hr1_d       = cmos_href;
    d1_d        = cmos_data;
    vs2_d       = vs1_q;
    hr2_d       = hr1_q;
    state_d     = state_q;
    skip_d      = skip_q;
    phase_d     = phase_q;
    y_d         = y_q;
    col_d       = col_q;
    row_d       = row_q;
    cam_y_d     = cam_y_q;
    cam_valid_d = 1'b0;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    fs_d        = 1'b0;
    fe_d        = 1'b0;
    err_d       = err_q;

    if (hr1_q) begin
      phase_d = ~cur_phase;
      if (!cur_phase) y_d = d1_q;
    end
    if (hr_rise) col_d = '0;

    // Column keeps counting past IMG_W so overlong lines stay detectable
    if (pix_done) begin
      if (col_q != '1) col_d = col_q + 1'b1;
      if (active) begin
        if (col_q < W_N && row_q < H_N) begin
          cam_valid_d = 1'b1;
          cam_y_d     = quant(y_q);
          pix_x_d     = col_q[9:0];
          pix_y_d     = row_q[8:0];
        end else begin
          err_d = 1'b1;
        end
      end
    end

    if (hr_fall) begin
      phase_d = 1'b0;
      if (active) begin
        if (phase_q || col_q < W_N) err_d = 1'b1;
        if (row_q != '1) row_d = row_q + 1'b1;
      end
    end

    case (state_q)
      ST_SKIP: begin
        if (vs_rise && skip_q != SKIP_N) begin
          skip_d = SKW'(skip_q + 1'b1);
          if (SKW'(skip_q + 1'b1) == SKIP_N) state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (vs_fall) begin
          fs_d    = 1'b1;
          state_d = ST_ACTIVE;
          row_d   = '0;
          col_d   = '0;
        end
      end
      ST_ACTIVE: begin
        if (vs_rise) begin
          fe_d    = 1'b1;
          state_d = ST_WAIT;
          phase_d = 1'b0;
          if (hr1_q || rows_done < H_N) err_d = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      vs1_q       <= 1'b0;
      hr1_q       <= 1'b0;
      d1_q        <= '0;
      vs2_q       <= 1'b0;
      hr2_q       <= 1'b0;
      skip_q      <= '0;
      phase_q     <= 1'b0;
      y_q         <= '0;
      col_q       <= '0;
      row_q       <= '0;
      cam_y_q     <= '0;
      cam_valid_q <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      fs_q        <= 1'b0;
      fe_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      vs1_q       <= vs1_d;
      hr1_q       <= hr1_d;
      d1_q        <= d1_d;
      vs2_q       <= vs2_d;
      hr2_q       <= hr2_d;
      skip_q      <= skip_d;
      phase_q     <= phase_d;
      y_q         <= y_d;
      col_q       <= col_d;
      row_q       <= row_d;
      cam_y_q     <= cam_y_d;
      cam_valid_q <= cam_valid_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      fs_q        <= fs_d;
      fe_q        <= fe_d;
      err_q       <= err_d;
    end
  end

  assign cam_y       = cam_y_q;
  assign cam_valid   = cam_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign frame_start = fs_q;
  assign frame_end   = fe_q;
  assign cap_err     = err_q;

endmodule
